hazard_scoreboard: RTL and testbench

- Parametrised hazard and forwarding unit for the decode stage. It replaces fixed EX/MEM compare logic with a DEPTH-entry in-flight writer pipeline and a per-register pending scoreboard for long-latency ops (div/mul).
- Produces one-hot forward selects for rs1/rs2 and a single stall request to the HDU.
- Sits beside the decode stage; its shift pipeline advances in lock-step with ID→EX and later stages.

---
 rtl/hazard_scoreboard.sv | 222 ++++++++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Decode-stage hazard and forwarding unit.
//  * Tracks the register writers in flight in a DEPTH-entry shift pipeline that
//    moves in lock-step with the ID->EX->...->WB stages (entry 0 = EX).
//  * Keeps a per-register pending bit for long-latency ops (div/mul). These ops
//    never enter the forwarding pipeline; their result only becomes visible
//    after the matching long_done writeback.
//  * Drives one-hot forward selects for rs1/rs2 and a single stall request.
//
// Optional build macro: HAZARD_STATS_EN
//  Defining it adds two 32-bit wrapping counters of stall cycles, one per cause
//  (load-use, long-op). With it undefined, neither the ports nor the counters
//  exist.
//
// Ports
//  clk, rst           clock, asynchronous active-high reset
//  adv                pipeline advances this cycle (0 = hold all entries)
//  issue_*            instruction currently in ID: valid, writes rd, rd id,
//                     is a load, is a long-latency op
//  rs1_*/rs2_*        source operand read enables and ids of the ID instruction
//  flush_mask         per-entry invalidate, applied at the clock edge
//  long_done(_regid)  long op writeback and its destination register
//  rs1/rs2_fwd_sel    one-hot forward source (all-zero = register file)
//  stall_req          ID must stall
//  long_cnt           number of outstanding long ops
//  stat_*_stalls      (HAZARD_STATS_EN only) stall-cycle counters
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int RID_W    = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 2,
    parameter int MAX_LONG = 4,
    localparam int CNT_W   = $clog2(MAX_LONG + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic             issue_valid,
    input  logic             issue_reg_write,
    input  logic [RID_W-1:0] issue_regid,
    input  logic             issue_load,
    input  logic             issue_long,
    input  logic             rs1_read,
    input  logic [RID_W-1:0] rs1_regid,
    input  logic             rs2_read,
    input  logic [RID_W-1:0] rs2_regid,
    input  logic [DEPTH-1:0] flush_mask,
    input  logic             long_done,
    input  logic [RID_W-1:0] long_done_regid,
    output logic [DEPTH-1:0] rs1_fwd_sel,
    output logic [DEPTH-1:0] rs2_fwd_sel,
    output logic             stall_req,
    output logic [CNT_W-1:0] long_cnt
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]      stat_load_stalls,
    output logic [31:0]      stat_long_stalls
`endif
);

    // -------------------------------------------------------------------------
    // In-flight writer pipeline
    // -------------------------------------------------------------------------
    logic [DEPTH-1:0] v_q, v_d;
    logic [DEPTH-1:0] load_q, load_d;
    logic [RID_W-1:0] regid_q [DEPTH];
    logic [RID_W-1:0] regid_d [DEPTH];

    always_comb begin
        v_d     = v_q;
        load_d  = load_q;
        regid_d = regid_q;
        if (adv) begin
            // Long ops are excluded: their result is not available in any
            // stage, the pending scoreboard covers them instead.
            v_d[0]     = issue_valid & issue_reg_write & ~issue_long &
                         (issue_regid != '0);
            regid_d[0] = issue_regid;
            load_d[0]  = issue_load;
            for (int k = 1; k < DEPTH; k++) begin
                v_d[k]     = v_q[k-1];
                regid_d[k] = regid_q[k-1];
                load_d[k]  = load_q[k-1];
            end
        end
        // Flush acts on whatever would land in the entry, advancing or not.
        v_d = v_d & ~flush_mask;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q    <= '0;
            load_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                regid_q[k] <= '0;
            end
        end else begin
            v_q     <= v_d;
            load_q  <= load_d;
            regid_q <= regid_d;
        end
    end

    // -------------------------------------------------------------------------
    // Operand match and youngest-writer selection
    // -------------------------------------------------------------------------
    logic [DEPTH-1:0] rs1_match, rs2_match;
    logic [DEPTH-1:0] early_mask;   // entries whose load data is not yet ready
    logic [DEPTH-1:0] rs1_sel, rs2_sel;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_match
            assign rs1_match[gi]  = v_q[gi] & rs1_read & (rs1_regid != '0) &
                                    (regid_q[gi] == rs1_regid);
            assign rs2_match[gi]  = v_q[gi] & rs2_read & (rs2_regid != '0) &
                                    (regid_q[gi] == rs2_regid);
            assign early_mask[gi] = (gi < LOAD_LAT);
        end
    endgenerate

    // x & -x isolates the lowest set bit, i.e. the youngest matching writer.
    assign rs1_sel     = rs1_match & (~rs1_match + DEPTH'(1));
    assign rs2_sel     = rs2_match & (~rs2_match + DEPTH'(1));
    assign rs1_fwd_sel = rs1_sel;
    assign rs2_fwd_sel = rs2_sel;

    logic load_use;
    assign load_use = (|(rs1_sel & load_q & early_mask)) |
                      (|(rs2_sel & load_q & early_mask));

    // -------------------------------------------------------------------------
    // Long-op pending scoreboard and outstanding counter
    // -------------------------------------------------------------------------
    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic [CNT_W-1:0]    long_cnt_q, long_cnt_d;
    logic                set_long, dec_long;

    assign set_long = adv & issue_valid & issue_long & issue_reg_write &
                      (issue_regid != '0);
    // A completion with nothing outstanding is a stray and is ignored.
    assign dec_long = long_done & (long_cnt_q != '0);

    always_comb begin
        pend_d = pend_q;
        if (long_done) begin
            pend_d[long_done_regid] = 1'b0;
        end
        // Applied after the clear so a same-register set wins.
        if (set_long) begin
            pend_d[issue_regid] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_comb begin
        long_cnt_d = long_cnt_q;
        if (set_long && !dec_long && (long_cnt_q != CNT_W'(MAX_LONG))) begin
            long_cnt_d = long_cnt_q + CNT_W'(1);
        end else if (dec_long && !set_long) begin
            long_cnt_d = long_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q     <= '0;
            long_cnt_q <= '0;
        end else begin
            pend_q     <= pend_d;
            long_cnt_q <= long_cnt_d;
        end
    end

    assign long_cnt = long_cnt_q;

    // Uses registered pend only, so a long_done this cycle releases the stall
    // on the following cycle.
    logic long_stall;
    assign long_stall = (pend_q[rs1_regid] & rs1_read) |
                        (pend_q[rs2_regid] & rs2_read) |
                        (pend_q[issue_regid] & issue_reg_write) |
                        (issue_long & (long_cnt_q == CNT_W'(MAX_LONG)));

    assign stall_req = issue_valid & (load_use | long_stall);

`ifdef HAZARD_STATS_EN
    // -------------------------------------------------------------------------
    // Stall statistics (wrap at 2^32)
    // -------------------------------------------------------------------------
    logic [31:0] stat_load_q, stat_load_d;
    logic [31:0] stat_long_q, stat_long_d;

    always_comb begin
        stat_load_d = stat_load_q;
        stat_long_d = stat_long_q;
        if (issue_valid & load_use) begin
            stat_load_d = stat_load_q + 32'd1;
        end
        if (issue_valid & long_stall) begin
            stat_long_d = stat_long_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_load_q <= '0;
            stat_long_q <= '0;
        end else begin
            stat_load_q <= stat_load_d;
            stat_long_q <= stat_long_d;
        end
    end

    assign stat_load_stalls = stat_load_q;
    assign stat_long_stalls = stat_long_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Self-checking bench for hazard_scoreboard (DEPTH=3, LOAD_LAT=2, MAX_LONG=4).
// Each step drives the ID-stage inputs just after a rising edge and pushes the
// expected {rs1_fwd_sel, rs2_fwd_sel, stall_req, long_cnt} into a queue; the
// scenario task pops it and compares mid-cycle. The inputs of a step are
// committed by the rising edge that starts the next step.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

    localparam int RID_W = 5;
    localparam int DEPTH = 3;
    localparam int CW    = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             adv;
    logic             issue_valid;
    logic             issue_reg_write;
    logic [RID_W-1:0] issue_regid;
    logic             issue_load;
    logic             issue_long;
    logic             rs1_read;
    logic [RID_W-1:0] rs1_regid;
    logic             rs2_read;
    logic [RID_W-1:0] rs2_regid;
    logic [DEPTH-1:0] flush_mask;
    logic             long_done;
    logic [RID_W-1:0] long_done_regid;
    logic [DEPTH-1:0] rs1_fwd_sel;
    logic [DEPTH-1:0] rs2_fwd_sel;
    logic             stall_req;
    logic [CW-1:0]    long_cnt;
`ifdef HAZARD_STATS_EN
    logic [31:0]      stat_load_stalls;
    logic [31:0]      stat_long_stalls;
`endif

    hazard_scoreboard #(
        .NUM_REGS (32),
        .RID_W    (RID_W),
        .DEPTH    (DEPTH),
        .LOAD_LAT (2),
        .MAX_LONG (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .adv             (adv),
        .issue_valid     (issue_valid),
        .issue_reg_write (issue_reg_write),
        .issue_regid     (issue_regid),
        .issue_load      (issue_load),
        .issue_long      (issue_long),
        .rs1_read        (rs1_read),
        .rs1_regid       (rs1_regid),
        .rs2_read        (rs2_read),
        .rs2_regid       (rs2_regid),
        .flush_mask      (flush_mask),
        .long_done       (long_done),
        .long_done_regid (long_done_regid),
        .rs1_fwd_sel     (rs1_fwd_sel),
        .rs2_fwd_sel     (rs2_fwd_sel),
        .stall_req       (stall_req),
        .long_cnt        (long_cnt)
`ifdef HAZARD_STATS_EN
        ,
        .stat_load_stalls(stat_load_stalls),
        .stat_long_stalls(stat_long_stalls)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [9:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    logic [9:0] obs;
    assign obs = {rs1_fwd_sel, rs2_fwd_sel, stall_req, long_cnt};

    function automatic logic [9:0] ex(input logic [2:0] f1, input logic [2:0] f2,
                                      input logic st, input logic [2:0] cnt);
        return {f1, f2, st, cnt};
    endfunction

    task automatic clear_inputs();
        adv             = 1'b0;
        issue_valid     = 1'b0;
        issue_reg_write = 1'b0;
        issue_regid     = '0;
        issue_load      = 1'b0;
        issue_long      = 1'b0;
        rs1_read        = 1'b0;
        rs1_regid       = '0;
        rs2_read        = 1'b0;
        rs2_regid       = '0;
        flush_mask      = '0;
        long_done       = 1'b0;
        long_done_regid = '0;
    endtask

    // Drive one cycle of stimulus and queue its expected outputs.
    task automatic step(input string nm, input logic a, input logic iv, input logic iw,
                        input logic [4:0] ird, input logic il, input logic ilg,
                        input logic r1, input logic [4:0] s1,
                        input logic r2, input logic [4:0] s2,
                        input logic [2:0] fl, input logic ld, input logic [4:0] ldr,
                        input logic [9:0] ev);
        @(posedge clk);
        #1;
        adv             = a;
        issue_valid     = iv;
        issue_reg_write = iw;
        issue_regid     = ird;
        issue_load      = il;
        issue_long      = ilg;
        rs1_read        = r1;
        rs1_regid       = s1;
        rs2_read        = r2;
        rs2_regid       = s2;
        flush_mask      = fl;
        long_done       = ld;
        long_done_regid = ldr;
        exp_q.push_back('{nm, ev});
    endtask

    // Empty the writer pipeline (pending long ops are unaffected).
    task automatic idle_flush();
        @(posedge clk);
        #1;
        clear_inputs();
        adv        = 1'b1;
        flush_mask = 3'b111;
    endtask

    task automatic test_reset();
        exp_t e;
        step("rst_hold_load", 1,1,1,7,1,0, 1,7,1,7, 3'b000, 0,0, ex(0,0,0,0));
        #3; e = exp_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
        else $display("ok   %s obs=%b", e.name, obs);
        step("rst_hold_long", 1,1,1,9,0,1, 1,9,0,0, 3'b000, 1,9, ex(0,0,0,0));
        #3; e = exp_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
        else $display("ok   %s obs=%b", e.name, obs);
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
    endtask

    task automatic test_forward();
        exp_t e;
        step("fwd_issue_x5", 1,1,1,5,0,0, 0,0,0,0, 3'b000, 0,0, ex(0,0,0,0));
        #3; e = exp_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
        else $display("ok   %s obs=%b", e.name, obs);
        step("fwd_ex", 1,1,0,0,0,0, 1,5,0,0, 3'b000, 0,0, ex(3'b001,0,0,0));
        #3; e = exp_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
        else $display("ok   %s obs=%b", e.name, obs);
        step("fwd_mem", 0,0,0,0,0,0, 1,5,1,5, 3'b000, 0,0, ex(3'b010,3'b010,0,0));
        #3; e = exp_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
        else $display("ok   %s obs=%b", e.name, obs);
        step("fwd_hold", 1,0,0,0,0,0, 1,5,0,0, 3'b000, 0,0, ex(3'b010,0,0,0));
        #3; e = exp_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
        else $display("ok   %s obs=%b", e.name, obs);
        step("fwd_wb", 1,0,0,0,0,0, 1,5,0,0, 3'b000, 0,0, ex(3'b100,0,0,0));
        #3; e = exp_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
        else $display("ok   %s obs=%b", e.name, obs);
        step("fwd_retired", 0,0,0,0,0,0, 1,5,1,5, 3'b000, 0,0, ex(0,0,0,0));
        #3; e = exp_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
        else $display("ok   %s obs=%b", e.name, obs);
    endtask

    task automatic test_load_use();
        exp_t e;
        step("ld_issue_x7", 1,1,1,7,1,0, 0,0,0,0, 3'b000, 0,0, ex(0,0,0,0));
        #3; e = exp_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
        else $display("ok   %s obs=%b", e.name, obs);
        step("ld_use_stage0", 1,1,0,0,0,0, 0,0,1,7, 3'b000, 0,0, ex(0,3'b001,1,0));
        #3; e = exp_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
        else $display("ok   %s obs=%b", e.name, obs);
        step("ld_use_stage1", 1,1,0,0,0,0, 0,0,1,7, 3'b000, 0,0, ex(0,3'b010,1,0));
        #3; e = exp_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
        else $display("ok   %s obs=%b", e.name, obs);
        step("ld_use_stage2", 1,1,0,0,0,0, 0,0,1,7, 3'b000, 0,0, ex(0,3'b100,0,0));
        #3; e = exp_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
        else $display("ok   %s obs=%b", e.name, obs);
    endtask

    task automatic test_youngest();
        exp_t e;
        step("yg_issue_x3", 1,1,1,3,0,0, 0,0,0,0, 3'b000, 0,0, ex(0,0,0,0));
        #3; e = exp_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
        else $display("ok   %s obs=%b", e.name, obs);
        step("yg_issue_x8", 1,1,1,8,0,0, 0,0,0,0, 3'b000, 0,0, ex(0,0,0,0));
        #3; e = exp_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
        else $display("ok   %s obs=%b", e.name, obs);
        step("yg_issue_x3_again", 1,1,1,3,0,0, 1,3,0,0, 3'b000, 0,0, ex(3'b010,0,0,0));
        #3; e = exp_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
        else $display("ok   %s obs=%b", e.name, obs);
        step("yg_pick_youngest", 0,0,0,0,0,0, 1,3,1,8, 3'b000, 0,0, ex(3'b001,3'b010,0,0));
        #3; e = exp_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
        else $display("ok   %s obs=%b", e.name, obs);
        step("yg_issue_x0", 1,1,1,0,0,0, 1,0,0,0, 3'b000, 0,0, ex(0,0,0,0));
        #3; e = exp_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
        else $display("ok   %s obs=%b", e.name, obs);
        step("yg_read_disabled", 0,0,0,0,0,0, 0,3,1,3, 3'b000, 0,0, ex(0,3'b010,0,0));
        #3; e = exp_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
        else $display("ok   %s obs=%b", e.name, obs);
        step("yg_read_x0", 0,0,0,0,0,0, 1,0,1,8, 3'b000, 0,0, ex(0,3'b100,0,0));
        #3; e = exp_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
        else $display("ok   %s obs=%b", e.name, obs);
    endtask

    task automatic test_long();
        exp_t e;
        step("lg_issue_x9", 1,1,1,9,0,1, 0,0,0,0, 3'b000, 0,0, ex(0,0,0,0));
        #3; e = exp_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
        else $display("ok   %s obs=%b", e.name, obs);
        step("lg_raw_stall", 0,1,0,0,0,0, 1,9,0,0, 3'b000, 0,0, ex(0,0,1,1));
        #3; e = exp_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
        else $display("ok   %s obs=%b", e.name, obs);
        step("lg_done_same_cycle", 0,1,0,0,0,0, 1,9,0,0, 3'b000, 1,9, ex(0,0,1,1));
        #3; e = exp_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
        else $display("ok   %s obs=%b", e.name, obs);
        step("lg_released", 0,1,0,0,0,0, 1,9,0,0, 3'b000, 0,0, ex(0,0,0,0));
        #3; e = exp_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
        else $display("ok   %s obs=%b", e.name, obs);
        for (int i = 0; i < 4; i++) begin
            step($sformatf("lg_fill_x%0d", 10 + i), 1,1,1,5'(10 + i),0,1, 0,0,0,0,
                 3'b000, 0,0, ex(0,0,0,3'(i)));
            #3; e = exp_q.pop_front(); total++;
            if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
            else $display("ok   %s obs=%b", e.name, obs);
        end
        step("lg_max_outstanding", 0,1,1,14,0,1, 0,0,0,0, 3'b000, 0,0, ex(0,0,1,4));
        #3; e = exp_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
        else $display("ok   %s obs=%b", e.name, obs);
        step("lg_waw", 0,1,1,10,0,0, 0,0,0,0, 3'b000, 0,0, ex(0,0,1,4));
        #3; e = exp_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
        else $display("ok   %s obs=%b", e.name, obs);
        step("lg_waw_not_valid", 0,0,1,10,0,0, 0,0,0,0, 3'b000, 0,0, ex(0,0,0,4));
        #3; e = exp_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
        else $display("ok   %s obs=%b", e.name, obs);
        step("lg_done_x10", 0,0,0,0,0,0, 0,0,0,0, 3'b000, 1,10, ex(0,0,0,4));
        #3; e = exp_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
        else $display("ok   %s obs=%b", e.name, obs);
        // Reissue x11 while its previous op completes: pend stays, count holds.
        step("lg_set_and_clear_x11", 1,1,1,11,0,1, 0,0,0,0, 3'b000, 1,11, ex(0,0,1,3));
        #3; e = exp_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
        else $display("ok   %s obs=%b", e.name, obs);
        step("lg_set_wins", 0,1,0,0,0,0, 1,11,0,0, 3'b000, 0,0, ex(0,0,1,3));
        #3; e = exp_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
        else $display("ok   %s obs=%b", e.name, obs);
        for (int i = 0; i < 3; i++) begin
            step($sformatf("lg_drain_x%0d", 11 + i), 0,0,0,0,0,0, 0,0,0,0,
                 3'b000, 1,5'(11 + i), ex(0,0,0,3'(3 - i)));
            #3; e = exp_q.pop_front(); total++;
            if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
            else $display("ok   %s obs=%b", e.name, obs);
        end
        step("lg_done_at_zero", 0,0,0,0,0,0, 0,0,0,0, 3'b000, 1,5, ex(0,0,0,0));
        #3; e = exp_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
        else $display("ok   %s obs=%b", e.name, obs);
        step("lg_all_clear", 0,1,0,0,0,0, 1,11,1,13, 3'b000, 0,0, ex(0,0,0,0));
        #3; e = exp_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
        else $display("ok   %s obs=%b", e.name, obs);
    endtask

    task automatic test_flush();
        exp_t e;
        step("fl_issue_load_x7", 1,1,1,7,1,0, 0,0,0,0, 3'b000, 0,0, ex(0,0,0,0));
        #3; e = exp_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
        else $display("ok   %s obs=%b", e.name, obs);
        step("fl_flush_stage0", 0,1,0,0,0,0, 0,0,1,7, 3'b001, 0,0, ex(0,3'b001,1,0));
        #3; e = exp_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
        else $display("ok   %s obs=%b", e.name, obs);
        step("fl_after_flush", 0,1,0,0,0,0, 0,0,1,7, 3'b000, 0,0, ex(0,0,0,0));
        #3; e = exp_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
        else $display("ok   %s obs=%b", e.name, obs);
    endtask

    task automatic test_reset_mid_stall();
        exp_t e;
        step("mr_issue_load_x7", 1,1,1,7,1,0, 0,0,0,0, 3'b000, 0,0, ex(0,0,0,0));
        #3; e = exp_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
        else $display("ok   %s obs=%b", e.name, obs);
        step("mr_issue_long_x20", 1,1,1,20,0,1, 0,0,1,7, 3'b000, 0,0, ex(0,3'b001,1,0));
        #3; e = exp_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
        else $display("ok   %s obs=%b", e.name, obs);
        step("mr_stalled", 0,1,0,0,0,0, 1,20,1,7, 3'b000, 0,0, ex(0,3'b010,1,1));
        #3; e = exp_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
        else $display("ok   %s obs=%b", e.name, obs);
        // Reset between clock edges: outputs must clear without waiting for clk.
        rst = 1'b1;
        exp_q.push_back('{"mr_async_reset", ex(0,0,0,0)});
        #2; e = exp_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
        else $display("ok   %s obs=%b", e.name, obs);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step("mr_post_reset", 0,1,0,0,0,0, 1,20,1,7, 3'b000, 0,0, ex(0,0,0,0));
        #3; e = exp_q.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.v); end
        else $display("ok   %s obs=%b", e.name, obs);
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        idle_flush();
        test_forward();
        idle_flush();
        test_load_use();
        idle_flush();
        test_youngest();
        idle_flush();
        test_long();
        idle_flush();
        test_flush();
        idle_flush();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
